clock_generator: RTL and testbench
==================================

// Module: clock_generator
//
// PURPOSE
//   Parameterised integer clock divider: derives clk_out = clk_in / DIVIDER with 50% duty cycle.
//   Sits at the clock-management level. Feeds slow-domain logic (timers, peripheral clocks) from a single fast source clock.
//   Odd ratios keep exact 50% duty by using a falling-edge helper flop.
//
// PARAMETERS
//   DIVIDER  10  integer division ratio, legal range 2..65535. Out-of-range values raise an elaboration-time error ($error/$fatal).
//   CNT_W    $clog2(DIVIDER)  counter width, derived (localparam, not overridable)
//
// PORTS
//   clk_in   in   1  source clock; all state advances on its rising edge (plus one falling-edge flop, odd DIVIDER only)
//   reset    in   1  asynchronous, active-low reset (0 = held in reset)
//   clk_out  out  1  divided clock, period DIVIDER x T(clk_in)
//
// BEHAVIOUR
//   - Reset (reset == 0): counter = 0, all flops = 0, clk_out = 0.
//     Takes effect immediately and asynchronously, including mid-period; no partial-period completion.
//   - Counter: after reset deasserts, counts clk_in rising edges 0..DIVIDER-1.
//     Wraps to 0 on the edge after DIVIDER-1.
//   - Edge index k: number of clk_in rising edges since reset deassertion.
//     k = 1 is the first rising edge seen with reset == 1.
//   - Even DIVIDER (N):
//     - clk_out rises on edge k = N/2 + m*N.
//     - clk_out falls on edge k = N + m*N (m = 0,1,2,...).
//     - High N/2 cycles, low N/2 cycles.
//     - clk_out is a direct flop output (toggle on half-count), glitch-free.
//   - Odd DIVIDER (N):
//     - clk_out rises on the clk_in falling edge that follows rising edge k = (N-1)/2 + m*N.
//     - clk_out falls on rising edge k = N + m*N.
//     - High time and low time are each N/2 clk_in periods (e.g. N=3: 1.5/1.5).
//     - Built as AND of a posedge flop and a negedge copy of it. Both are flops, so there is no combinational decode glitch.
//   - DIVIDER = 2: clk_out toggles on every clk_in rising edge, first rising edge of clk_out at k = 1.
//   - Frequency is exact: no drift over any number of periods.
//     The counter never exceeds DIVIDER-1; wrap is the only boundary.
//   - Reset deassertion: no synchroniser inside this block.
//     The integrator guarantees deassertion meets recovery/removal timing relative to clk_in.
//   - Reset reasserted mid-period: clk_out drops to 0 at once.
//     After release, the waveform restarts from k = 1 exactly as after power-up.
//   - No X propagation: outputs are defined from the moment reset is asserted.
//
// TESTING
//   T(clk_in) = 10 ns, clk_in starts low, rising edges at 5, 15, 25, ... ns.
//   1. DIVIDER=10; reset=0 for 0..20 ns, then 1.
//      -> clk_out = 0 through 65 ns. Rises at 65, falls at 115, rises at 165. Period 100 ns, high 50 ns, run 2000 ns with no drift.
//   2. DIVIDER=10; reset=0 at 300 ns (clk_out high), released at 320 ns.
//      -> clk_out = 0 at 300 ns immediately. Next rise at 365 ns.
//   3. DIVIDER=2; reset released at 20 ns.
//      -> clk_out rises at 25, falls at 35, period 20 ns.
//   4. DIVIDER=3; reset released at 20 ns.
//      -> clk_out rises at 30 ns (falling edge after k=1), falls at 45 ns. Period 30 ns, high 15 ns.
//   5. DIVIDER=5; reset released at 20 ns.
//      -> rises at 40 ns, falls at 65 ns, rises at 90 ns. High 25 ns, low 25 ns.
//   6. Checker on every test: clk_out has no pulse shorter than floor(N/2) x T, never X after reset, and never toggles while reset = 0.

Source files
------------

// File: rtl/clock_generator.sv
// Integer clock divider: clk_out = clk_in / DIVIDER with a 50% duty cycle.
// Even ratios come straight from a posedge flop. Odd ratios AND that flop
// with a negedge copy of itself, which delays the rising edge by half an
// input period and keeps the duty cycle exact.
module clock_generator #(
  parameter int DIVIDER = 10
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
);

  // Width guard keeps the counter legal while the range check below reports
  // an out-of-range ratio.
  localparam int CNT_W = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDER - 1);
  // floor(N/2): for even N the output rises at k = N/2.
  // For odd N the posedge flop rises at k = (N-1)/2, which is the same value.
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIVIDER / 2);

  if (DIVIDER < 2 || DIVIDER > 65535) begin : g_bad_divider
    $error("clock_generator: DIVIDER=%0d outside legal range 2..65535", DIVIDER);
  end

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pos;

  // After rising edge k the counter holds k mod N; wrap is the only boundary.
  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);

  // Counter and half-count flop. The flop is high for counts floor(N/2)..N-1.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_pos <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_pos <= (w_cnt_nxt >= HALF);
    end
  end

  if (DIVIDER % 2 == 1) begin : g_odd
    logic r_neg;

    // Half-cycle-delayed copy. The AND rises on the falling edge after r_pos
    // and falls together with r_pos, so both high and low times are N/2.
    always_ff @(negedge clk_in or negedge reset) begin
      if (!reset) r_neg <= 1'b0;
      else        r_neg <= r_pos;
    end

    assign clk_out = r_pos & r_neg;
  end else begin : g_even
    assign clk_out = r_pos;
  end

endmodule

// File: tb/tb_clock_generator.sv
// Bench for clock_generator: four instances (N = 10, 2, 3, 5) share a
// clock and a reset. A time-based reference model predicts every output level.
// A monitor compares the DUT output against those predictions half a cycle
// later. A pulse-width checker watches each output.
`timescale 1ns/100ps
module tb_clock_generator;

  localparam int NI = 4;

  function automatic int div_of(input int i);
    case (i)
      0:       return 10;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic [NI-1:0] clk_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference-model state, written by the stimulus process.
  bit in_reset = 1'b1;
  int e1       = 0;   // time (ns) of the first rising edge after release

  logic [NI-1:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    clock_generator #(.DIVIDER(div_of(g))) u_dut (
      .clk_in (clk_in),
      .reset  (reset),
      .clk_out(clk_out[g])
    );
  end

  // Reference level at time t. The waveform repeats every N input periods
  // (2N half-periods) after the first edge e1. It is high from half-period
  // N-2 up to, but not including, half-period 2N-2. This holds for both even
  // and odd N.
  function automatic logic ref_level(input int n, input real t);
    int h;
    if (in_reset || t < real'(e1)) return 1'b0;
    h = int'($floor((t - real'(e1)) / 5.0)) % (2 * n);
    return (h >= n - 2) && (h < 2 * n - 2);
  endfunction

  // Model: every 5 ns, push the expected levels for the sample taken 0.5 ns later.
  initial begin : model
    #2;
    forever begin
      logic [NI-1:0] e;
      for (int i = 0; i < NI; i++) e[i] = ref_level(div_of(i), $realtime + 0.5);
      exp_q.push_back(e);
      #5;
    end
  end

  // Monitor: samples 2.5 ns after each clk_in edge and pops the matching expectation.
  initial begin : monitor
    #2.5;
    forever begin
      logic [NI-1:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty t=%0t got=%b required=an expectation", $realtime, clk_out);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          n_checks++;
          if (clk_out[i] !== e[i]) begin
            n_errors++;
            $display("FAIL clk_out_div%0d t=%0t got=%b required=%b", div_of(i), $realtime, clk_out[i], e[i]);
          end
        end
      end
      #5;
    end
  end

  // Pulse checker:
  //  - no pulse shorter than floor(N/2) periods while running;
  //  - the output never rises while reset is held.
  for (genvar g = 0; g < NI; g++) begin : g_pw
    real last_t  = 0.0;
    bit  last_ok = 1'b0;
    always @(clk_out[g]) begin
      if (!reset) begin
        last_ok = 1'b0;
        n_checks++;
        if (clk_out[g] !== 1'b0) begin
          n_errors++;
          $display("FAIL toggle_in_reset_div%0d t=%0t got=%b required=0", div_of(g), $realtime, clk_out[g]);
        end
      end else begin
        if (last_ok) begin
          n_checks++;
          if ($realtime - last_t < real'((div_of(g) / 2) * 10)) begin
            n_errors++;
            $display("FAIL pulse_width_div%0d t=%0t got=%0.1fns required>=%0dns",
                     div_of(g), $realtime, $realtime - last_t, (div_of(g) / 2) * 10);
          end
        end
        last_t  = $realtime;
        last_ok = 1'b1;
      end
    end
  end

  task automatic assert_at(input int t);
    #(real'(t) - $realtime);
    reset    = 1'b0;
    in_reset = 1'b1;
    #0.1;
    n_checks++;
    if (clk_out !== '0) begin
      n_errors++;
      $display("FAIL reset_immediate t=%0t got=%b required=0000", $realtime, clk_out);
    end
  endtask

  task automatic release_at(input int t);
    #(real'(t) - $realtime);
    reset    = 1'b1;
    in_reset = 1'b0;
    e1       = ((t - 5) / 10) * 10 + 15;
  endtask

  initial begin : stim
    int t;
    int ta;
    int ao[4];
    int ro[5];
    ao = '{1, 4, 6, 9};
    ro = '{8, 9, 10, 11, 13};
    assert_at(0);
    release_at(20);
    assert_at(300);           // N=10 output is high here
    release_at(320);
    t = 2400;                 // long uninterrupted run checks for drift
    for (int i = 0; i < 10; i++) begin
      ta = t + 10 * int'($urandom_range(5, 250));
      assert_at(ta + ao[$urandom_range(0, 3)]);
      t = ta + 10 * int'($urandom_range(1, 4)) + ro[$urandom_range(0, 4)];
      release_at(t);
    end
    #500;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog t=%0t got=timeout required=stimulus complete", $realtime);
    $fatal(1, "watchdog expired");
  end

endmodule
